// File: rtl/tage_pkg.sv
// Shared TAGE maintenance definitions: security domains, table-select masks
// and the flush/ageing sequencer state encoding.
package tage_pkg;

    localparam int TAGE_IDX_WIDTH = 9;
    localparam int TAGE_N_TBL     = 5;

    typedef logic [1:0] domain_t;
    localparam domain_t DOM_INIT = 2'd0;

    localparam logic [TAGE_N_TBL-1:0] TBL_T0     = 5'b00001;
    localparam logic [TAGE_N_TBL-1:0] TBL_T1     = 5'b00010;
    localparam logic [TAGE_N_TBL-1:0] TBL_T2     = 5'b00100;
    localparam logic [TAGE_N_TBL-1:0] TBL_T3     = 5'b01000;
    localparam logic [TAGE_N_TBL-1:0] TBL_T4     = 5'b10000;
    localparam logic [TAGE_N_TBL-1:0] TBL_TAGGED = TBL_T1 | TBL_T2 | TBL_T3 | TBL_T4;
    localparam logic [TAGE_N_TBL-1:0] TBL_ALL    = TBL_T0 | TBL_TAGGED;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_FLUSH = 2'd1,
        FSM_AGE   = 2'd2,
        FSM_ACK   = 2'd3
    } flush_state_e;

    // Ageing only touches the tagged tables; the bimodal T0 has no u bits.
    function automatic logic [TAGE_N_TBL-1:0] sweep_tbl(input flush_state_e st);
        logic [TAGE_N_TBL-1:0] sel;
        sel = '0;
        if (st == FSM_FLUSH) begin
            sel = TBL_ALL;
        end else if (st == FSM_AGE) begin
            sel = TBL_TAGGED;
        end
        return sel;
    endfunction

endpackage

// File: rtl/tage_age_timer.sv
// Counts resolved branches and raises a pending-ageing flag every
// 2**AGE_LOG2 branches until the sequencer consumes or cancels it.
module tage_age_timer #(
    parameter int AGE_LOG2 = 18
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cnt_en_i,
    input  logic clr_all_i,
    input  logic clr_pend_i,
    output logic age_pend_o
);

    logic [AGE_LOG2-1:0] cnt_q, cnt_d;
    logic                pend_q, pend_d;

    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (clr_all_i) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else begin
            if (clr_pend_i) begin
                pend_d = 1'b0;
            end
            if (cnt_en_i) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    pend_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign age_pend_o = pend_q;

endmodule

// File: rtl/tage_flush_ctrl.sv
// TAGE maintenance sequencer: full-table clear sweeps on domain change or
// request, and periodic usefulness-bit ageing sweeps over the tagged tables.
module tage_flush_ctrl
    import tage_pkg::*;
#(
    parameter int SWEEP_W  = TAGE_IDX_WIDTH,
    parameter int AGE_LOG2 = 18,
    parameter int N_TBL    = TAGE_N_TBL
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  domain_t            domain_i,
    input  logic               br_valid_i,
    input  logic               flush_req_i,
    output logic               flush_ack_o,
    output logic               stall_o,
    output logic               clr_we_o,
    output logic [SWEEP_W-1:0] clr_idx_o,
    output logic [N_TBL-1:0]   clr_tbl_o,
    output logic               clr_full_o,
    output logic               clr_ubit_o,
    output logic               busy_o
);

    flush_state_e       state_q, state_d;
    logic [SWEEP_W-1:0] idx_q, idx_d;
    domain_t            last_dom_q;
    logic               req_seen_q, req_seen_d;
    logic               ubit_sel_q, ubit_sel_d;

    logic               age_pend;
    logic               age_clr_all;
    logic               age_clr_pend;
    logic               dom_chg;
    logic               trigger;

    logic               ack_q, ack_d;
    logic               stall_q, stall_d;
    logic               we_q, we_d;
    logic [SWEEP_W-1:0] oidx_q, oidx_d;
    logic [N_TBL-1:0]   tbl_q, tbl_d;
    logic               full_q, full_d;
    logic               oubit_q, oubit_d;
    logic               busy_q, busy_d;

    // A held request only counts once; it must drop before it can re-arm.
    assign dom_chg = (domain_i != last_dom_q);
    assign trigger = dom_chg | (flush_req_i & ~req_seen_q);

    tage_age_timer #(
        .AGE_LOG2 (AGE_LOG2)
    ) u_age_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cnt_en_i   (br_valid_i & ~stall_q),
        .clr_all_i  (age_clr_all),
        .clr_pend_i (age_clr_pend),
        .age_pend_o (age_pend)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ubit_sel_d   = ubit_sel_q;
        req_seen_d   = flush_req_i ? req_seen_q : 1'b0;
        age_clr_all  = 1'b0;
        age_clr_pend = 1'b0;
        case (state_q)
            FSM_IDLE: begin
                if (trigger) begin
                    state_d    = FSM_FLUSH;
                    idx_d      = '0;
                    req_seen_d = flush_req_i;
                end else if (age_pend) begin
                    state_d = FSM_AGE;
                    idx_d   = '0;
                end
            end
            FSM_FLUSH: begin
                if (trigger) begin
                    idx_d      = '0;
                    req_seen_d = flush_req_i;
                end else if (idx_q == '1) begin
                    state_d = FSM_ACK;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            FSM_AGE: begin
                if (trigger) begin
                    state_d      = FSM_FLUSH;
                    idx_d        = '0;
                    req_seen_d   = flush_req_i;
                    age_clr_pend = 1'b1;
                end else if (idx_q == '1) begin
                    state_d      = FSM_IDLE;
                    idx_d        = '0;
                    ubit_sel_d   = ~ubit_sel_q;
                    age_clr_pend = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            FSM_ACK: begin
                // The flush just zeroed every u bit, so pending ageing is moot.
                state_d     = FSM_IDLE;
                age_clr_all = 1'b1;
            end
            default: begin
                state_d = FSM_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave flops directly.
    always_comb begin
        ack_d   = 1'b0;
        stall_d = 1'b0;
        we_d    = 1'b0;
        oidx_d  = '0;
        tbl_d   = '0;
        full_d  = 1'b0;
        oubit_d = 1'b0;
        busy_d  = 1'b0;
        case (state_d)
            FSM_FLUSH: begin
                stall_d = 1'b1;
                we_d    = 1'b1;
                oidx_d  = idx_d;
                tbl_d   = N_TBL'(sweep_tbl(FSM_FLUSH));
                full_d  = 1'b1;
                busy_d  = 1'b1;
            end
            FSM_AGE: begin
                stall_d = 1'b1;
                we_d    = 1'b1;
                oidx_d  = idx_d;
                tbl_d   = N_TBL'(sweep_tbl(FSM_AGE));
                oubit_d = ubit_sel_q;
                busy_d  = 1'b1;
            end
            FSM_ACK: begin
                ack_d   = 1'b1;
                stall_d = 1'b1;
                busy_d  = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= FSM_IDLE;
            idx_q      <= '0;
            last_dom_q <= DOM_INIT;
            req_seen_q <= 1'b0;
            ubit_sel_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_dom_q <= domain_i;
            req_seen_q <= req_seen_d;
            ubit_sel_q <= ubit_sel_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            oidx_q  <= '0;
            tbl_q   <= '0;
            full_q  <= 1'b0;
            oubit_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            oidx_q  <= oidx_d;
            tbl_q   <= tbl_d;
            full_q  <= full_d;
            oubit_q <= oubit_d;
            busy_q  <= busy_d;
        end
    end

    assign flush_ack_o = ack_q;
    assign stall_o     = stall_q;
    assign clr_we_o    = we_q;
    assign clr_idx_o   = oidx_q;
    assign clr_tbl_o   = tbl_q;
    assign clr_full_o  = full_q;
    assign clr_ubit_o  = oubit_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_tage_flush_ctrl.sv
// Self-checking bench for tage_flush_ctrl: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_tage_flush_ctrl;
    import tage_pkg::*;

    localparam int SW     = 9;
    localparam int AGEL   = 4;
    localparam int SWEEP  = 1 << SW;
    localparam int AGEP   = 1 << AGEL;

    localparam int M_IDLE  = 0;
    localparam int M_FLUSH = 1;
    localparam int M_AGE   = 2;
    localparam int M_ACK   = 3;

    logic          clk;
    logic          rst;
    domain_t       domain;
    logic          brValid;
    logic          flushReq;
    logic          flush_ack_o;
    logic          stall_o;
    logic          clr_we_o;
    logic [SW-1:0] clr_idx_o;
    logic [4:0]    clr_tbl_o;
    logic          clr_full_o;
    logic          clr_ubit_o;
    logic          busy_o;

    int vectors     = 0;
    int miscompares = 0;
    int ackCount    = 0;
    int weCount     = 0;
    int stallCount  = 0;

    tage_flush_ctrl #(
        .SWEEP_W  (SW),
        .AGE_LOG2 (AGEL),
        .N_TBL    (5)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .domain_i    (domain),
        .br_valid_i  (brValid),
        .flush_req_i (flushReq),
        .flush_ack_o (flush_ack_o),
        .stall_o     (stall_o),
        .clr_we_o    (clr_we_o),
        .clr_idx_o   (clr_idx_o),
        .clr_tbl_o   (clr_tbl_o),
        .clr_full_o  (clr_full_o),
        .clr_ubit_o  (clr_ubit_o),
        .busy_o      (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: what sweep is running, how far it got, and the
    // bookkeeping the rules require (branch count, pending age, u-bit choice).
    typedef struct {
        int      mode;
        int      pos;
        int      ubit;
        int      brCount;
        bit      pend;
        domain_t lastDom;
        bit      served;
    } model_t;

    model_t m;

    function automatic model_t resetModel();
        model_t r;
        r.mode    = M_IDLE;
        r.pos     = 0;
        r.ubit    = 1;
        r.brCount = 0;
        r.pend    = 1'b0;
        r.lastDom = DOM_INIT;
        r.served  = 1'b0;
        return r;
    endfunction

    function automatic model_t modelStep(model_t cur, domain_t dom, bit req, bit br);
        model_t nx = cur;
        bit want = (dom != cur.lastDom) || (req && !cur.served);
        bit startFlush = 1'b0;
        nx.lastDom = dom;
        if (cur.mode == M_IDLE) begin
            if (want) startFlush = 1'b1;
            else if (cur.pend) begin
                nx.mode = M_AGE;
                nx.pos  = 0;
            end
        end else if (cur.mode == M_FLUSH) begin
            if (want) startFlush = 1'b1;
            else if (cur.pos == SWEEP - 1) begin
                nx.mode = M_ACK;
                nx.pos  = 0;
            end else nx.pos = cur.pos + 1;
        end else if (cur.mode == M_AGE) begin
            if (want) begin
                startFlush = 1'b1;
                nx.pend    = 1'b0;
            end else if (cur.pos == SWEEP - 1) begin
                nx.mode = M_IDLE;
                nx.pos  = 0;
                nx.ubit = 1 - cur.ubit;
                nx.pend = 1'b0;
            end else nx.pos = cur.pos + 1;
        end else begin
            nx.mode    = M_IDLE;
            nx.brCount = 0;
            nx.pend    = 1'b0;
        end
        if (startFlush) begin
            nx.mode   = M_FLUSH;
            nx.pos    = 0;
            nx.served = req;
        end else if (!req) begin
            nx.served = 1'b0;
        end
        if (cur.mode == M_IDLE && br) begin
            nx.brCount = (cur.brCount + 1) % AGEP;
            if (nx.brCount == 0) nx.pend = 1'b1;
        end
        return nx;
    endfunction

    function automatic logic [19:0] expectVec(model_t s);
        bit writing = (s.mode == M_FLUSH) || (s.mode == M_AGE);
        logic [SW-1:0] idx = writing ? SW'(s.pos) : '0;
        logic [4:0] tbl = (s.mode == M_FLUSH) ? 5'h1f : ((s.mode == M_AGE) ? 5'h1e : 5'h00);
        logic ub = (s.mode == M_AGE) ? s.ubit[0] : 1'b0;
        return {s.mode == M_ACK, s.mode != M_IDLE, writing, idx, tbl,
                s.mode == M_FLUSH, ub, s.mode != M_IDLE};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= resetModel();
        else     m <= modelStep(m, domain, flushReq, brValid);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("cycle", {12'd0, flush_ack_o, stall_o, clr_we_o, clr_idx_o, clr_tbl_o,
                              clr_full_o, clr_ubit_o, busy_o}, {12'd0, expectVec(m)});
        if (flush_ack_o) ackCount++;
        if (clr_we_o)    weCount++;
        if (stall_o)     stallCount++;
    end

    task automatic applyStimulus(input domain_t dom, input logic req, input logic br);
        domain   = dom;
        flushReq = req;
        brValid  = br;
    endtask

    task automatic waitBusy(input logic want, input int budget, input string name);
        int n = 0;
        while (busy_o !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, busy_o}, {31'd0, want});
    endtask

    task automatic pulses(input domain_t dom, input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(dom, 1'b0, 1'b1);
            @(negedge clk);
        end
        applyStimulus(dom, 1'b0, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ack0, we0, st0;
        rst = 1'b1;
        applyStimulus(2'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {flush_ack_o, stall_o, clr_we_o, clr_idx_o, clr_tbl_o,
                                      clr_full_o, clr_ubit_o, busy_o}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Domain INIT -> D1: 512 full writes, ack, then idle.
        ack0 = ackCount; we0 = weCount;
        applyStimulus(2'd1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("p1_first", {stall_o, clr_we_o, clr_full_o, clr_tbl_o, clr_idx_o},
                    {1'b1, 1'b1, 1'b1, 5'h1f, 9'd0});
        repeat (SWEEP - 1) @(negedge clk);
        checkOutput("p1_last_idx", {23'd0, clr_we_o, clr_idx_o}, {23'd0, 1'b1, 9'd511});
        @(negedge clk);
        checkOutput("p1_ack", {stall_o, clr_we_o, flush_ack_o}, {1'b1, 1'b0, 1'b1});
        @(negedge clk);
        checkOutput("p1_idle", {stall_o, busy_o, flush_ack_o}, 3'b000);
        checkOutput("p1_writes", weCount - we0, 512);
        checkOutput("p1_acks", ackCount - ack0, 1);

        // Held request: exactly one sweep until it drops and rises again.
        ack0 = ackCount; we0 = weCount;
        applyStimulus(2'd1, 1'b1, 1'b0);
        repeat (1100) @(negedge clk);
        checkOutput("p2_one_ack", ackCount - ack0, 1);
        checkOutput("p2_one_sweep", weCount - we0, 512);
        applyStimulus(2'd1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        ack0 = ackCount;
        applyStimulus(2'd1, 1'b1, 1'b0);
        repeat (600) @(negedge clk);
        checkOutput("p2_rearm_ack", ackCount - ack0, 1);
        applyStimulus(2'd1, 1'b0, 1'b0);
        @(negedge clk);

        // Domain change at idx 200 restarts the sweep with a single ack.
        ack0 = ackCount; st0 = stallCount;
        applyStimulus(2'd2, 1'b0, 1'b0);
        @(negedge clk);
        repeat (200) @(negedge clk);
        checkOutput("p3_idx200", clr_idx_o, 200);
        applyStimulus(2'd3, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("p3_restart", {stall_o, clr_we_o, clr_idx_o}, {1'b1, 1'b1, 9'd0});
        waitBusy(1'b0, 800, "p3_done");
        checkOutput("p3_stall_cycles", stallCount - st0, 201 + 512 + 1);
        checkOutput("p3_acks", ackCount - ack0, 1);

        // Two ageing sweeps alternate the cleared u bit, MSB first.
        pulses(2'd3, AGEP);
        checkOutput("p4_pend_latency", busy_o, 0);
        @(negedge clk);
        checkOutput("p4_age1", {clr_we_o, clr_full_o, clr_tbl_o, clr_ubit_o, clr_idx_o},
                    {1'b1, 1'b0, 5'h1e, 1'b1, 9'd0});
        waitBusy(1'b0, 600, "p4_age1_done");
        pulses(2'd3, AGEP);
        @(negedge clk);
        checkOutput("p4_age2", {clr_we_o, clr_full_o, clr_tbl_o, clr_ubit_o}, {1'b1, 1'b0, 5'h1e, 1'b0});
        waitBusy(1'b0, 600, "p4_age2_done");

        // Abort ageing at idx 50; u-bit selection must not advance.
        pulses(2'd3, AGEP);
        @(negedge clk);
        checkOutput("p5_age_ubit", clr_ubit_o, 1);
        repeat (50) @(negedge clk);
        checkOutput("p5_age_idx50", clr_idx_o, 50);
        applyStimulus(2'd2, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("p5_abort_flush", {clr_we_o, clr_full_o, clr_tbl_o, clr_idx_o},
                    {1'b1, 1'b1, 5'h1f, 9'd0});
        waitBusy(1'b0, 700, "p5_flush_done");
        pulses(2'd2, 5);
        applyStimulus(2'd3, 1'b0, 1'b0);
        @(negedge clk);
        waitBusy(1'b0, 700, "p5_flush2_done");
        pulses(2'd3, AGEP - 1);
        repeat (3) @(negedge clk);
        checkOutput("p5_cnt_restarted", busy_o, 0);
        pulses(2'd3, 1);
        @(negedge clk);
        checkOutput("p5_next_age", {clr_we_o, clr_tbl_o, clr_ubit_o}, {1'b1, 5'h1e, 1'b1});
        waitBusy(1'b0, 600, "p5_age_done");

        // Asynchronous reset in the middle of a flush.
        ack0 = ackCount;
        applyStimulus(2'd1, 1'b0, 1'b0);
        @(negedge clk);
        repeat (300) @(negedge clk);
        checkOutput("p6_idx300", clr_idx_o, 300);
        #2 rst = 1'b1;
        applyStimulus(2'd0, 1'b0, 1'b0);
        #1;
        checkOutput("p6_async_zero", {flush_ack_o, stall_o, clr_we_o, clr_idx_o, clr_tbl_o,
                                      clr_full_o, clr_ubit_o, busy_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("p6_idle_after", busy_o, 0);
        checkOutput("p6_no_ack", ackCount - ack0, 0);

        // Randomised traffic checked only by the model.
        for (int c = 0; c < 6000; c++) begin
            domain_t d = domain;
            logic r = flushReq;
            if ($urandom_range(0, 399) == 0) d = domain_t'($urandom_range(0, 3));
            if (!r && $urandom_range(0, 299) == 0) r = 1'b1;
            else if (r && $urandom_range(0, 39) == 0) r = 1'b0;
            applyStimulus(d, r, logic'($urandom_range(0, 1)));
            @(negedge clk);
        end
        applyStimulus(domain, 1'b0, 1'b0);
        @(negedge clk);
        waitBusy(1'b0, 1200, "rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
